// File: rtl/unidade_controle_jogadas.sv
// Moore control unit for the sequence-memory game: sequences the counter, memory,
// switch register and comparator, and reports hit / miss / timeout endings.
module unidade_controle_jogadas #(
  parameter int unsigned TIMEOUT = 5000,
  parameter int unsigned TW      = 13
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic       jogada_feita,
  input  logic       igual,
  input  logic       fimC,
  output logic       zeraC,
  output logic       contaC,
  output logic       zeraR,
  output logic       registraR,
  output logic       pronto,
  output logic       acertou,
  output logic       errou,
  output logic       timeout,
  output logic [3:0] db_estado
);

  typedef enum logic [3:0] {
    INICIAL     = 4'b0000,
    PREPARACAO  = 4'b0001,
    ESPERA      = 4'b0010,
    REGISTRA    = 4'b0100,
    COMPARACAO  = 4'b0101,
    PROXIMO     = 4'b0110,
    FIM_ACERTO  = 4'b1010,
    FIM_ERRO    = 4'b1110,
    FIM_TIMEOUT = 4'b1101
  } state_e;

  localparam bit            T_EN   = (TIMEOUT != 0);
  localparam logic [TW-1:0] T_LAST = TW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  state_e        state_q, state_d;
  logic          jogada_prev_q, jogada_prev_d;
  logic [TW-1:0] tcount_q, tcount_d;
  logic          evento;

  logic       zera_c_q, zera_c_d;
  logic       conta_c_q, conta_c_d;
  logic       zera_r_q, zera_r_d;
  logic       registra_r_q, registra_r_d;
  logic       pronto_q, pronto_d;
  logic       acertou_q, acertou_d;
  logic       errou_q, errou_d;
  logic       timeout_q, timeout_d;
  logic [3:0] db_estado_q, db_estado_d;

  // Rising edge of "any switch active"; a held switch never re-triggers.
  assign evento        = jogada_feita & ~jogada_prev_q;
  assign jogada_prev_d = jogada_feita;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q       <= INICIAL;
      jogada_prev_q <= 1'b0;
      tcount_q      <= '0;
      zera_c_q      <= 1'b0;
      conta_c_q     <= 1'b0;
      zera_r_q      <= 1'b0;
      registra_r_q  <= 1'b0;
      pronto_q      <= 1'b0;
      acertou_q     <= 1'b0;
      errou_q       <= 1'b0;
      timeout_q     <= 1'b0;
      db_estado_q   <= 4'b0000;
    end else begin
      state_q       <= state_d;
      jogada_prev_q <= jogada_prev_d;
      tcount_q      <= tcount_d;
      zera_c_q      <= zera_c_d;
      conta_c_q     <= conta_c_d;
      zera_r_q      <= zera_r_d;
      registra_r_q  <= registra_r_d;
      pronto_q      <= pronto_d;
      acertou_q     <= acertou_d;
      errou_q       <= errou_d;
      timeout_q     <= timeout_d;
      db_estado_q   <= db_estado_d;
    end
  end

  // Next state and per-move timeout counter.
  always_comb begin
    state_d  = state_q;
    tcount_d = tcount_q;
    case (state_q)
      INICIAL: begin
        if (iniciar) state_d = PREPARACAO;
      end
      PREPARACAO: begin
        tcount_d = '0;
        state_d  = ESPERA;
      end
      ESPERA: begin
        tcount_d = tcount_q + TW'(1);
        if (evento) begin
          state_d = REGISTRA;
        end else if (T_EN && (tcount_q == T_LAST)) begin
          state_d = FIM_TIMEOUT;
        end
      end
      REGISTRA: begin
        state_d = COMPARACAO;
      end
      COMPARACAO: begin
        if (!igual)    state_d = FIM_ERRO;
        else if (fimC) state_d = FIM_ACERTO;
        else           state_d = PROXIMO;
      end
      PROXIMO: begin
        tcount_d = '0;
        state_d  = ESPERA;
      end
      FIM_ACERTO, FIM_ERRO, FIM_TIMEOUT: begin
        if (iniciar) state_d = PREPARACAO;
      end
      default: begin
        state_d = INICIAL;
      end
    endcase
  end

  // Outputs decoded from the next state so the registered copies track state_q exactly.
  always_comb begin
    zera_c_d     = 1'b0;
    conta_c_d    = 1'b0;
    zera_r_d     = 1'b0;
    registra_r_d = 1'b0;
    pronto_d     = 1'b0;
    acertou_d    = 1'b0;
    errou_d      = 1'b0;
    timeout_d    = 1'b0;
    db_estado_d  = 4'(state_d);
    case (state_d)
      PREPARACAO: begin
        zera_c_d = 1'b1;
        zera_r_d = 1'b1;
      end
      REGISTRA:   registra_r_d = 1'b1;
      PROXIMO:    conta_c_d    = 1'b1;
      FIM_ACERTO: begin
        pronto_d  = 1'b1;
        acertou_d = 1'b1;
      end
      FIM_ERRO: begin
        pronto_d = 1'b1;
        errou_d  = 1'b1;
      end
      FIM_TIMEOUT: begin
        pronto_d  = 1'b1;
        errou_d   = 1'b1;
        timeout_d = 1'b1;
      end
      default: ;
    endcase
  end

  assign zeraC     = zera_c_q;
  assign contaC    = conta_c_q;
  assign zeraR     = zera_r_q;
  assign registraR = registra_r_q;
  assign pronto    = pronto_q;
  assign acertou   = acertou_q;
  assign errou     = errou_q;
  assign timeout   = timeout_q;
  assign db_estado = db_estado_q;

endmodule
